stack_calc_core: RTL and testbench

- Parametrised successor to the 4-bit stack calculator core: generic data width and stack depth.
- Adds a valid/ready opcode handshake, stack overflow/underflow detection, a SUB binary op, and a 2*WIDTH output register.
- Sits between the pin-level wrapper (which supplies the opcode stream) and the output multiplexer / seven-segment decoder.

---
 rtl/stack_calc_core.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_stack_calc_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_calc_core.sv
// Parametrised stack calculator core: valid/ready opcode intake, 2*WIDTH output register, sticky status.
// Optional RAM for SAVE/LOAD is compiled in with `define STACK_CALC_RAM_EN.
//
// state | meaning
// IDLE  | ready for an op, latches op_code/op_data on handshake
// EXEC  | operand check and primary stack update
// WB2   | second write of MULT (high), IDIV (remainder), LOAD (read data)
module stack_calc_core #(
    parameter int WIDTH         = 4,
    parameter int DEPTH         = 8,
    parameter int MEM_ADDR_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [3:0]                   op_code,
    input  logic [WIDTH-1:0]             op_data,
    output logic [WIDTH-1:0]             top_word,
    output logic [WIDTH-1:0]             second_word,
    output logic [2*WIDTH-1:0]           out_word,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         carry_flag,
    output logic                         error_flag,
    output logic                         overflow_flag,
    output logic                         underflow_flag
);

    localparam int DW = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_OUTL = 4'h3;
    localparam logic [3:0] OP_OUTH = 4'h4;
    localparam logic [3:0] OP_SWAP = 4'h5;
    localparam logic [3:0] OP_PUSF = 4'h6;
    localparam logic [3:0] OP_REPL = 4'h7;
    localparam logic [3:0] OP_BINA = 4'h8;
    localparam logic [3:0] OP_MULT = 4'h9;
    localparam logic [3:0] OP_IDIV = 4'hA;
    localparam logic [3:0] OP_CLFL = 4'hB;
    localparam logic [3:0] OP_SAVE = 4'hC;
    localparam logic [3:0] OP_LOAD = 4'hD;
    localparam logic [3:0] OP_CLRS = 4'hE;

    if (WIDTH < 4 || DEPTH < 2 || MEM_ADDR_BITS < 1) begin : g_param_check
        $error("stack_calc_core: requires WIDTH>=4, DEPTH>=2, MEM_ADDR_BITS>=1");
    end

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB2} state_t;
    typedef enum logic [2:0] {SOP_NONE, SOP_PUSH, SOP_POP, SOP_POP2, SOP_REDUCE} sop_t;

    state_t               state_q, state_d;
    logic [3:0]           code_q, code_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [WIDTH-1:0]     stk_q [DEPTH];
    logic [WIDTH-1:0]     stk_d [DEPTH];
    logic [DW-1:0]        depth_q, depth_d;
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]     wb_q, wb_d;
    logic                 carry_q, carry_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    sop_t                 sop;
    logic [WIDTH-1:0]     sval;
    logic [1:0]           need;
    logic                 is_push;
    logic [2:0]           sub_op;
    logic [WIDTH-1:0]     t_w, s_w;
    logic                 cin;
    logic [WIDTH:0]       sum_w;
    logic [2*WIDTH-1:0]   prod_w;
    logic                 div_zero;
    logic [WIDTH-1:0]     quot_w, rem_w;
    logic [WIDTH-1:0]     repl_w, bina_w, pusf_w;
    logic                 bina_cupd, bina_c;

    // Entry 0 is the top of stack; entries at or beyond depth are don't-care and hidden on the outputs.
    assign t_w    = stk_q[0];
    assign s_w    = stk_q[1];
    assign sub_op = data_q[2:0];

    assign op_ready       = rst_n && (state_q == S_IDLE);
    assign top_word       = (depth_q != '0) ? stk_q[0] : '0;
    assign second_word    = (depth_q >= DW'(2)) ? stk_q[1] : '0;
    assign out_word       = out_q;
    assign depth          = depth_q;
    assign carry_flag     = carry_q;
    assign error_flag     = err_q;
    assign overflow_flag  = ovf_q;
    assign underflow_flag = unf_q;

    assign cin      = (sub_op == 3'd4) && carry_q;
    assign sum_w    = {1'b0, s_w} + {1'b0, t_w} + (WIDTH+1)'(cin);
    assign prod_w   = {{WIDTH{1'b0}}, s_w} * {{WIDTH{1'b0}}, t_w};
    assign div_zero = (t_w == '0);
    assign quot_w   = div_zero ? '0 : s_w / t_w;
    assign rem_w    = div_zero ? '0 : s_w % t_w;
    assign is_push  = (code_q == OP_PUSH) || (code_q == OP_PUSF);

`ifdef STACK_CALC_RAM_EN
    localparam int MEM_WORDS = 2 ** MEM_ADDR_BITS;
    logic [WIDTH-1:0]         mem_q [MEM_WORDS];
    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic                     mem_we;

    assign mem_addr = MEM_ADDR_BITS'(t_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[mem_addr] <= s_w;
        end
    end
`endif

    always_comb begin
        need = 2'd0;
        case (code_q)
            OP_POP, OP_SWAP, OP_REPL, OP_OUTL, OP_OUTH: need = 2'd1;
            OP_BINA, OP_MULT, OP_IDIV:                  need = 2'd2;
            OP_PUSF: begin
                if (sub_op == 3'd0)      need = 2'd1;
                else if (sub_op == 3'd1) need = 2'd2;
            end
`ifdef STACK_CALC_RAM_EN
            OP_SAVE: need = 2'd2;
            OP_LOAD: need = 2'd1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        case (sub_op)
            3'd0:    repl_w = ~t_w;
            3'd1:    repl_w = '0 - t_w;
            3'd2:    repl_w = t_w + WIDTH'(1);
            3'd3:    repl_w = t_w - WIDTH'(1);
            3'd4:    repl_w = t_w >> 1;
            3'd5:    repl_w = t_w << 1;
            3'd6:    repl_w = {t_w[0], t_w[WIDTH-1:1]};
            default: repl_w = {t_w[WIDTH-2:0], t_w[WIDTH-1]};
        endcase
    end

    always_comb begin
        bina_w    = '0;
        bina_cupd = 1'b0;
        bina_c    = 1'b0;
        case (sub_op)
            3'd0, 3'd4: begin
                bina_w    = sum_w[WIDTH-1:0];
                bina_cupd = 1'b1;
                bina_c    = sum_w[WIDTH];
            end
            3'd1:    bina_w = s_w & t_w;
            3'd2:    bina_w = s_w | t_w;
            3'd3:    bina_w = s_w ^ t_w;
            3'd5:    bina_w = prod_w[WIDTH-1:0];
            3'd6:    bina_w = prod_w[2*WIDTH-1:WIDTH];
            default: begin
                bina_w    = s_w - t_w;
                bina_cupd = 1'b1;
                bina_c    = (s_w < t_w);
            end
        endcase
    end

    always_comb begin
        case (sub_op)
            3'd0:    pusf_w = t_w;
            3'd1:    pusf_w = s_w;
            3'd2:    pusf_w = WIDTH'({ovf_q, unf_q, err_q, carry_q});
            default: pusf_w = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        data_d  = data_q;
        stk_d   = stk_q;
        depth_d = depth_q;
        out_d   = out_q;
        wb_d    = wb_q;
        carry_d = carry_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        sop     = SOP_NONE;
        sval    = '0;
`ifdef STACK_CALC_RAM_EN
        mem_we  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready) begin
                    code_d  = op_code;
                    data_d  = op_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                if (depth_q < DW'(need)) begin
                    unf_d = 1'b1;
                    err_d = 1'b1;
                end else if (is_push && depth_q == DW'(DEPTH)) begin
                    ovf_d = 1'b1;
                    err_d = 1'b1;
                end else begin
                    case (code_q)
                        OP_PUSH: begin sop = SOP_PUSH; sval = data_q; end
                        OP_POP:  sop = SOP_POP;
                        OP_OUTL: out_d[WIDTH-1:0] = t_w;
                        OP_OUTH: out_d[2*WIDTH-1:WIDTH] = t_w;
                        OP_SWAP: begin
                            stk_d[0] = second_word;
                            stk_d[1] = t_w;
                        end
                        OP_PUSF: begin sop = SOP_PUSH; sval = pusf_w; end
                        OP_REPL: stk_d[0] = repl_w;
                        OP_BINA: begin
                            sop  = SOP_REDUCE;
                            sval = bina_w;
                            if (bina_cupd) carry_d = bina_c;
                        end
                        OP_MULT: begin
                            sop     = SOP_REDUCE;
                            sval    = prod_w[WIDTH-1:0];
                            wb_d    = prod_w[2*WIDTH-1:WIDTH];
                            state_d = S_WB2;
                        end
                        OP_IDIV: begin
                            sop     = SOP_REDUCE;
                            sval    = quot_w;
                            wb_d    = rem_w;
                            state_d = S_WB2;
                            if (div_zero) err_d = 1'b1;
                        end
                        OP_CLFL: begin
                            carry_d = 1'b0;
                            err_d   = 1'b0;
                            ovf_d   = 1'b0;
                            unf_d   = 1'b0;
                        end
`ifdef STACK_CALC_RAM_EN
                        OP_SAVE: begin
                            mem_we = 1'b1;
                            sop    = SOP_POP2;
                        end
                        OP_LOAD: begin
                            wb_d    = mem_q[mem_addr];
                            state_d = S_WB2;
                        end
`endif
                        OP_CLRS: depth_d = '0;
                        default: ;
                    endcase
                end
            end
            S_WB2: begin
                state_d = S_IDLE;
                if (code_q == OP_LOAD) begin
                    stk_d[0] = wb_q;
                end else begin
                    sop  = SOP_PUSH;
                    sval = wb_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (sop)
            SOP_PUSH: begin
                for (int i = DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
                stk_d[0] = sval;
                depth_d  = depth_q + DW'(1);
            end
            SOP_POP: begin
                for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                stk_d[DEPTH-1] = '0;
                depth_d        = depth_q - DW'(1);
            end
            SOP_POP2: begin
                for (int i = 0; i < DEPTH - 2; i++) stk_d[i] = stk_q[i+2];
                stk_d[DEPTH-2] = '0;
                stk_d[DEPTH-1] = '0;
                depth_d        = depth_q - DW'(2);
            end
            SOP_REDUCE: begin
                for (int i = 1; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                stk_d[DEPTH-1] = '0;
                stk_d[0]       = sval;
                depth_d        = depth_q - DW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
            depth_q <= '0;
            out_q   <= '0;
            wb_q    <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            data_q  <= data_d;
            stk_q   <= stk_d;
            depth_q <= depth_d;
            out_q   <= out_d;
            wb_q    <= wb_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: tb/tb_stack_calc_core.sv
// Directed bench for stack_calc_core (WIDTH=4, DEPTH=8); expectations follow STACK_CALC_RAM_EN when defined.
module tb_stack_calc_core;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int DW = $clog2(D + 1);

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           op_valid = 1'b0;
    logic [3:0]     op_code  = 4'h0;
    logic [W-1:0]   op_data  = '0;
    logic           op_ready;
    logic [W-1:0]   top_word, second_word;
    logic [2*W-1:0] out_word;
    logic [DW-1:0]  depth;
    logic           carry_flag, error_flag, overflow_flag, underflow_flag;
    logic [3:0]     flags;

    int n_checks = 0;
    int n_fail   = 0;

    assign flags = {overflow_flag, underflow_flag, error_flag, carry_flag};

    stack_calc_core #(.WIDTH(W), .DEPTH(D), .MEM_ADDR_BITS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_code        (op_code),
        .op_data        (op_data),
        .top_word       (top_word),
        .second_word    (second_word),
        .out_word       (out_word),
        .depth          (depth),
        .carry_flag     (carry_flag),
        .error_flag     (error_flag),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int cnt = 0;
        while (!op_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: op_ready observed 0 after 20 cycles, expected 1", tag);
        end
    endtask

    // Present one op at a negedge; returns at the negedge after the accept edge (core in EXEC).
    task automatic issue(input logic [3:0] c, input logic [W-1:0] d);
        @(negedge clk);
        wait_ready("issue_ready");
        op_valid = 1'b1;
        op_code  = c;
        op_data  = d;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] c, input logic [W-1:0] d);
        issue(c, d);
        wait_ready("op_done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", op_ready, 0);
        check("rst_depth", depth, 0);
        check("rst_top", top_word, 0);
        check("rst_second", second_word, 0);
        check("rst_out", out_word, 0);
        check("rst_flags", flags, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", op_ready, 1);

        // two-edge latency of a single-cycle op
        issue(4'h1, 4'd3);
        check("lat_exec_depth", depth, 0);
        check("lat_exec_ready", op_ready, 0);
        @(negedge clk);
        check("lat_done_depth", depth, 1);
        check("lat_done_top", top_word, 3);
        check("lat_done_ready", op_ready, 1);

        // ADD without and with carry out
        do_op(4'h1, 4'd5);
        do_op(4'h8, 4'd0);
        check("add_top", top_word, 8);
        check("add_depth", depth, 1);
        check("add_flags", flags, 4'b0000);
        do_op(4'h1, 4'd9);
        do_op(4'h8, 4'd0);
        check("addc_top", top_word, 1);
        check("addc_flags", flags, 4'b0001);
        do_op(4'hB, 4'd0);
        check("clfl_flags", flags, 4'b0000);
        do_op(4'hE, 4'd0);
        check("clrs_depth", depth, 0);
        check("clrs_top", top_word, 0);

        // MULT 9*9 = 0x51, three-edge latency
        do_op(4'h1, 4'd9);
        do_op(4'h1, 4'd9);
        issue(4'h9, 4'd0);
        check("mult_exec_ready", op_ready, 0);
        @(negedge clk);
        check("mult_wb2_ready", op_ready, 0);
        check("mult_wb2_depth", depth, 1);
        check("mult_wb2_top", top_word, 1);
        @(negedge clk);
        check("mult_top", top_word, 5);
        check("mult_second", second_word, 1);
        check("mult_depth", depth, 2);
        check("mult_ready", op_ready, 1);

        // IDIV 7/2
        do_op(4'h1, 4'd7);
        do_op(4'h1, 4'd2);
        do_op(4'hA, 4'd0);
        check("idiv_top", top_word, 1);
        check("idiv_second", second_word, 3);
        check("idiv_depth", depth, 4);

        // output register halves; stack 1,3,5,1
        do_op(4'h3, 4'd0);
        check("outl", out_word, 8'h01);
        do_op(4'h2, 4'd0);
        check("pop_top", top_word, 3);
        check("pop_depth", depth, 3);
        do_op(4'h4, 4'd0);
        check("outh", out_word, 8'h31);

        // SUB, borrow, ADDC, high product
        do_op(4'h1, 4'd2);
        do_op(4'h8, 4'd7);
        check("sub_top", top_word, 1);
        check("sub_flags", flags, 4'b0000);
        do_op(4'h8, 4'd7);
        check("sub2_top", top_word, 4);
        do_op(4'h1, 4'd6);
        do_op(4'h8, 4'd7);
        check("borrow_top", top_word, 4'hE);
        check("borrow_flags", flags, 4'b0001);
        check("borrow_depth", depth, 2);
        do_op(4'h1, 4'd3);
        do_op(4'h8, 4'd4);
        check("addc_cin_top", top_word, 2);
        check("addc_cin_flags", flags, 4'b0001);
        do_op(4'h1, 4'd9);
        do_op(4'h8, 4'd6);
        check("mulhi_top", top_word, 1);
        check("mulhi_second", second_word, 1);

        // REPL sub-ops on T=1
        do_op(4'h7, 4'd0);
        check("repl_not", top_word, 4'hE);
        do_op(4'h7, 4'd1);
        check("repl_neg", top_word, 2);
        do_op(4'h7, 4'd7);
        check("repl_rol", top_word, 4);
        do_op(4'h7, 4'd6);
        check("repl_ror", top_word, 2);
        check("repl_depth", depth, 2);

        // PUSF status/peek, SWAP, XOR; stack 2,1 with carry=1
        do_op(4'h6, 4'd2);
        check("pusf_status", top_word, 1);
        check("pusf_depth", depth, 3);
        do_op(4'h6, 4'd1);
        check("pusf_peek", top_word, 2);
        do_op(4'h5, 4'd0);
        check("swap_top", top_word, 1);
        check("swap_second", second_word, 2);
        do_op(4'h8, 4'd3);
        check("xor_top", top_word, 3);
        check("xor_depth", depth, 3);

        // divide by zero
        do_op(4'hB, 4'd0);
        do_op(4'h1, 4'd7);
        do_op(4'h1, 4'd0);
        do_op(4'hA, 4'd0);
        check("div0_top", top_word, 0);
        check("div0_second", second_word, 0);
        check("div0_depth", depth, 5);
        check("div0_flags", flags, 4'b0010);
        do_op(4'hB, 4'd0);
        check("div0_clfl", flags, 4'b0000);

        // overflow at DEPTH
        do_op(4'hE, 4'd0);
        for (int i = 1; i <= D; i++) do_op(4'h1, W'(i));
        check("full_depth", depth, D);
        check("full_flags", flags, 4'b0000);
        do_op(4'h1, 4'd9);
        check("ovf_depth", depth, D);
        check("ovf_top", top_word, 8);
        check("ovf_second", second_word, 7);
        check("ovf_flags", flags, 4'b1010);

        // underflow on empty stack
        do_op(4'hB, 4'd0);
        do_op(4'hE, 4'd0);
        do_op(4'h2, 4'd0);
        check("unf_depth", depth, 0);
        check("unf_flags", flags, 4'b0110);
        do_op(4'hB, 4'd0);

        // SAVE/LOAD
        do_op(4'hE, 4'd0);
        do_op(4'h1, 4'd6);
        do_op(4'h1, 4'd2);
        do_op(4'hC, 4'd0);
`ifdef STACK_CALC_RAM_EN
        check("save_depth", depth, 0);
`else
        check("save_depth", depth, 2);
`endif
        do_op(4'h1, 4'd2);
        do_op(4'hD, 4'd0);
`ifdef STACK_CALC_RAM_EN
        check("load_top", top_word, 6);
        check("load_depth", depth, 1);
`else
        check("load_top", top_word, 2);
        check("load_depth", depth, 3);
`endif
        check("load_flags", flags, 4'b0000);
        do_op(4'hF, 4'd5);
        do_op(4'h0, 4'd5);
`ifdef STACK_CALC_RAM_EN
        check("noop_depth", depth, 1);
`else
        check("noop_depth", depth, 3);
`endif

        // reset during WB2 of MULT
        do_op(4'hE, 4'd0);
        do_op(4'h2, 4'd0);
        do_op(4'h1, 4'd9);
        do_op(4'h3, 4'd0);
        check("pre_rst_out", out_word, 8'h39);
        check("pre_rst_flags", flags, 4'b0110);
        do_op(4'h1, 4'd9);
        issue(4'h9, 4'd0);
        @(negedge clk);
        check("pre_rst_wb2_ready", op_ready, 0);
        check("pre_rst_wb2_depth", depth, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_depth", depth, 0);
        check("midrst_flags", flags, 4'b0000);
        check("midrst_out", out_word, 0);
        check("midrst_top", top_word, 0);
        check("midrst_ready", op_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", op_ready, 1);
        check("post_rst_depth", depth, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
